// File: rtl/count_slot_arbiter.sv
// count_slot_arbiter
// Round-robin arbiter that lends one slot counter to NREQ requesters.
// The winner owns the counter for L = clamp(len, 1..MAX_LEN) cycles. During
// that time the counter runs 0..L-1. The slot ends with a one-cycle done pulse,
// or with an abort pulse if the owner drops its request before the slot ends.
// The next arbitration happens in the release cycle, so one dead cycle always
// separates two grants.
module count_slot_arbiter #(
    parameter int unsigned    NREQ    = 4,
    parameter int unsigned    CW      = 8,
    parameter logic [CW-1:0]  MAX_LEN = CW'(15)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [CW-1:0]        count,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      abort
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] abort_q, abort_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   len_q, len_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;

    logic            any_req;
    logic            owner_req;
    logic            at_terminal;
    logic [PW-1:0]   win_idx;
    logic [CW-1:0]   win_raw;
    logic [CW-1:0]   win_len;
    logic [PW-1:0]   rr_next;

    // Returns the first set request at or after ptr, wrapping past NREQ-1.
    // The loop runs from the farthest offset down to the nearest one, so the
    // nearest hit is written last and wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] pick;
        logic [PW:0]   cand;
        pick = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (r[cand[PW-1:0]]) begin
                pick = cand[PW-1:0];
            end
        end
        return pick;
    endfunction

    assign any_req     = |req;
    assign owner_req   = req[owner_q];
    assign at_terminal = (count_q == (len_q - CW'(1)));
    assign win_idx     = rr_pick(req, rr_ptr_q);
    assign rr_next     = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    // Select the winner's length field and clamp it to 1..MAX_LEN.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        win_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_raw = len[i*CW +: CW];
            end
        end
        if (win_raw == '0) begin
            win_len = CW'(1);
        end else if (win_raw > MAX_LEN) begin
            win_len = MAX_LEN;
        end else begin
            win_len = win_raw;
        end
    end

    // State register: IDLE/RUN with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start a slot on any request; leave RUN on terminal or drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_RUN;
            ST_RUN:  if (!owner_req || at_terminal) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: grant/latch in IDLE; count, then release in RUN.
    always_comb begin
        grant_d  = grant_q;
        busy_d   = busy_q;
        count_d  = count_q;
        len_d    = len_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = '0;
        abort_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    busy_d  = 1'b1;
                    count_d = '0;
                    len_d   = win_len;
                    owner_d = win_idx;
                end
            end
            ST_RUN: begin
                if (!owner_req || at_terminal) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    count_d  = '0;
                    rr_ptr_d = rr_next;
                    // A dropped request takes priority over a terminal count on the same edge.
                    if (!owner_req) begin
                        abort_d[owner_q] = 1'b1;
                    end else begin
                        done_d[owner_q] = 1'b1;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // Output and slot-context registers. A reset drops any running slot without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            count_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            len_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            len_q    <= len_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign done  = done_q;
    assign abort = abort_q;

endmodule
